// File: rtl/mcu_pkg.sv
// Shared definitions for the multi-cycle control unit.
// Contents: opcode encodings, condition codes, NZCV flag bit positions,
// the FSM state type, and opcode classification helpers used by the top.
package mcu_pkg;

    // Opcode encodings (5-bit field at the top of the instruction word)
    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_ADD   = 5'b00110;
    localparam logic [4:0] OP_SUB   = 5'b00111;
    localparam logic [4:0] OP_AND   = 5'b01000;
    localparam logic [4:0] OP_ORR   = 5'b01001;
    localparam logic [4:0] OP_LOAD  = 5'b10011;
    localparam logic [4:0] OP_STORE = 5'b10100;
    localparam logic [4:0] OP_B     = 5'b11000;

    // Condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Bit positions inside flags = {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK
    } state_t;

    function automatic logic is_alu_op(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_ORR);
    endfunction

    function automatic logic is_mem_op(input logic [4:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic is_legal_op(input logic [4:0] op);
        return is_alu_op(op) || is_mem_op(op) || (op == OP_NOP) || (op == OP_B);
    endfunction

endpackage

// File: rtl/cond_check.sv
// Condition-code evaluator.
// Ports: cond (4-bit condition field), flags ({N,Z,C,V}),
//        pass (1 when the instruction should execute).
// Unlisted condition encodings never execute.
module cond_check
    import mcu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass =  flags[FLAG_Z];
            COND_NE: pass = ~flags[FLAG_Z];
            COND_CS: pass =  flags[FLAG_C];
            COND_CC: pass = ~flags[FLAG_C];
            COND_MI: pass =  flags[FLAG_N];
            COND_PL: pass = ~flags[FLAG_N];
            COND_VS: pass =  flags[FLAG_V];
            COND_VC: pass = ~flags[FLAG_V];
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: latches the fetched instruction into IR and
// sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK, with conditional execution
// against NZCV and stalls on instruction/data memory handshakes.
// Inputs : clk, rst (async, active low), instruction, instr_valid, flags,
//          mem_ready.
// Outputs: instr_req, ir_write, pc_write, pc_src, mem_read, mem_write,
//          mem_to_reg, reg_write, flag_write, alu_ctrl, alu_src, imm_src,
//          illegal (one-cycle pulse), retired_count (wrapping).
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int word_size   = 32,
    parameter int opcode_size = 5,
    parameter int cnt_width   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [word_size-1:0]   instruction,
    input  logic                   instr_valid,
    input  logic [3:0]             flags,
    input  logic                   mem_ready,
    output logic                   instr_req,
    output logic                   ir_write,
    output logic                   pc_write,
    output logic                   pc_src,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   mem_to_reg,
    output logic                   reg_write,
    output logic                   flag_write,
    output logic [opcode_size-1:0] alu_ctrl,
    output logic                   alu_src,
    output logic                   imm_src,
    output logic                   illegal,
    output logic [cnt_width-1:0]   retired_count
);

    localparam int CondHi = word_size - opcode_size - 1;

    state_t                 state_q, state_d;
    logic [word_size-1:0]   ir_q;
    logic [cnt_width-1:0]   count_q;
    logic                   retire;
    logic                   cond_pass;

    logic [opcode_size-1:0] opcode;
    logic [3:0]             cond;
    logic                   i_bit, s_bit, x_bit;

    assign opcode = ir_q[word_size-1 -: opcode_size];
    assign cond   = ir_q[CondHi -: 4];
    assign i_bit  = ir_q[CondHi-4];
    assign s_bit  = ir_q[CondHi-5];
    assign x_bit  = ir_q[CondHi-6];

    // Register/immediate fields below the control bits belong to the datapath
    // (it keeps its own IR copy via ir_write); fold them here so they are
    // visibly intentional rather than forgotten.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir_q[CondHi-7:0];

    cond_check u_cond_check (
        .cond  (cond),
        .flags (flags),
        .pass  (cond_pass)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (ir_write) begin
                ir_q <= instruction;
            end
            if (retire) begin
                count_q <= count_q + {{(cnt_width-1){1'b0}}, 1'b1};
            end
        end
    end

    assign retired_count = count_q;

    // Outputs depend only on state and IR (plus the handshake/flag inputs that
    // select the exit path); while reset is held every strobe is forced low.
    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        instr_req  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        flag_write = 1'b0;
        alu_ctrl   = '0;
        alu_src    = 1'b0;
        imm_src    = 1'b0;
        illegal    = 1'b0;
        if (rst) begin
            case (state_q)
                S_FETCH: begin
                    instr_req = 1'b1;
                    if (instr_valid) begin
                        ir_write = 1'b1;
                        state_d  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Annulment takes priority over the illegal-opcode trap.
                    if (!cond_pass) begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end else if (!is_legal_op(opcode)) begin
                        illegal  = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end else if (opcode == OP_NOP) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (is_alu_op(opcode)) begin
                        alu_ctrl   = opcode;
                        alu_src    = i_bit;
                        imm_src    = x_bit;
                        flag_write = s_bit;
                        state_d    = S_WRITEBACK;
                    end else if (is_mem_op(opcode)) begin
                        // Address = base + sign-extended offset
                        alu_ctrl = OP_ADD;
                        alu_src  = 1'b1;
                        imm_src  = 1'b1;
                        state_d  = S_MEM;
                    end else begin
                        pc_src   = 1'b1;
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                end
                S_MEM: begin
                    mem_read  = (opcode == OP_LOAD);
                    mem_write = (opcode != OP_LOAD);
                    if (mem_ready) begin
                        if (opcode == OP_LOAD) begin
                            state_d = S_WRITEBACK;
                        end else begin
                            pc_write = 1'b1;
                            retire   = 1'b1;
                            state_d  = S_FETCH;
                        end
                    end
                end
                S_WRITEBACK: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (opcode == OP_LOAD);
                    pc_write   = 1'b1;
                    retire     = 1'b1;
                    state_d    = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit. Stimulus is generated per
// instruction; the expected output vector for each cycle is written by the
// stimulus process and compared against the DUT by one negedge process.
module tb_multicycle_control_unit;

    localparam int W  = 32;
    localparam int O  = 5;
    localparam int CW = 2;

    localparam logic [4:0] NOP = 5'b00000, ADD = 5'b00110, SUB = 5'b00111,
                           ANDO = 5'b01000, ORR = 5'b01001, LD = 5'b10011,
                           ST = 5'b10100, BR = 5'b11000;
    localparam logic [3:0] AL = 4'b1110, EQ = 4'b0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  instruction;
    logic          instr_valid;
    logic [3:0]    flags;
    logic          mem_ready;
    logic          instr_req, ir_write, pc_write, pc_src, mem_read, mem_write;
    logic          mem_to_reg, reg_write, flag_write, alu_src, imm_src, illegal;
    logic [O-1:0]  alu_ctrl;
    logic [CW-1:0] retired_count;

    always #5 clk = ~clk;

    multicycle_control_unit #(
        .word_size   (W),
        .opcode_size (O),
        .cnt_width   (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst_n),
        .instruction   (instruction),
        .instr_valid   (instr_valid),
        .flags         (flags),
        .mem_ready     (mem_ready),
        .instr_req     (instr_req),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .flag_write    (flag_write),
        .alu_ctrl      (alu_ctrl),
        .alu_src       (alu_src),
        .imm_src       (imm_src),
        .illegal       (illegal),
        .retired_count (retired_count)
    );

    typedef struct packed {
        logic          instr_req;
        logic          ir_write;
        logic          pc_write;
        logic          pc_src;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
        logic          reg_write;
        logic          flag_write;
        logic [4:0]    alu_ctrl;
        logic          alu_src;
        logic          imm_src;
        logic          illegal;
        logic [CW-1:0] cnt;
    } obs_t;

    obs_t exp_o, act_o;
    int   total = 0;
    int   bad   = 0;
    bit   check_en = 1'b0;
    int   mcnt = 0;  // architectural count of retired instructions (unwrapped)

    always_comb act_o = {instr_req, ir_write, pc_write, pc_src, mem_read, mem_write,
                         mem_to_reg, reg_write, flag_write, alu_ctrl, alu_src,
                         imm_src, illegal, retired_count};

    always @(negedge clk) begin
        if (check_en) begin
            total++;
            if (act_o !== exp_o) begin
                bad++;
                $display("FAIL cycle_outputs t=%0t got=%h want=%h", $time, act_o, exp_o);
            end
        end
    end

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t base();
        obs_t o;
        o     = '0;
        o.cnt = CW'(mcnt % (1 << CW));
        return o;
    endfunction

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'd0: return z;
            4'd1: return !z;
            4'd2: return cf;
            4'd3: return !cf;
            4'd4: return n;
            4'd5: return !n;
            4'd6: return v;
            4'd7: return !v;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [W-1:0] mk(input logic [4:0] op, input logic [3:0] c,
                                        input bit ib, input bit sb, input bit xb);
        logic [W-1:0] r;
        r = $urandom;
        r[31:27] = op;
        r[26:23] = c;
        r[22]    = ib;
        r[21]    = sb;
        r[20]    = xb;
        return r;
    endfunction

    // Drive one instruction from FETCH back to FETCH, setting the expected
    // output vector for every cycle; lat returns the cycles spent.
    task automatic run_instr(input logic [W-1:0] ir, input int fstall,
                             input logic [3:0] fl, input int mstall, output int lat);
        logic [4:0] op;
        bit ld, is_alu, legal;
        op     = ir[31:27];
        ld     = (op == LD);
        is_alu = op inside {ADD, SUB, ANDO, ORR};
        legal  = is_alu || op inside {NOP, LD, ST, BR};
        lat    = 0;
        for (int k = 0; k < fstall; k++) begin
            instr_valid = 1'b0; instruction = $urandom; mem_ready = 1'($urandom); flags = 4'($urandom);
            exp_o = base(); exp_o.instr_req = 1'b1;
            step(); lat++;
        end
        instr_valid = 1'b1; instruction = ir;
        exp_o = base(); exp_o.instr_req = 1'b1; exp_o.ir_write = 1'b1;
        step(); lat++;
        // DECODE
        instr_valid = 1'($urandom); instruction = $urandom; mem_ready = 1'($urandom); flags = fl;
        exp_o = base();
        if (!cond_ok(ir[26:23], fl)) begin
            exp_o.pc_write = 1'b1; step(); lat++; return;
        end
        if (!legal) begin
            exp_o.pc_write = 1'b1; exp_o.illegal = 1'b1; step(); lat++; return;
        end
        if (op == NOP) begin
            exp_o.pc_write = 1'b1; step(); lat++; mcnt++; return;
        end
        step(); lat++;
        // EXECUTE
        instr_valid = 1'($urandom); mem_ready = 1'($urandom); flags = 4'($urandom);
        exp_o = base();
        if (op == BR) begin
            exp_o.pc_src = 1'b1; exp_o.pc_write = 1'b1; step(); lat++; mcnt++; return;
        end
        if (is_alu) begin
            exp_o.alu_ctrl = op; exp_o.alu_src = ir[22];
            exp_o.flag_write = ir[21]; exp_o.imm_src = ir[20];
            step(); lat++;
        end else begin
            exp_o.alu_ctrl = ADD; exp_o.alu_src = 1'b1; exp_o.imm_src = 1'b1;
            step(); lat++;
            // MEM
            for (int k = 0; k <= mstall; k++) begin
                instr_valid = 1'($urandom); flags = 4'($urandom);
                mem_ready = (k == mstall);
                exp_o = base(); exp_o.mem_read = ld; exp_o.mem_write = !ld;
                if (k == mstall && !ld) exp_o.pc_write = 1'b1;
                step(); lat++;
            end
            if (!ld) begin mcnt++; return; end
        end
        // WRITEBACK
        instr_valid = 1'($urandom); mem_ready = 1'($urandom); flags = 4'($urandom);
        exp_o = base(); exp_o.reg_write = 1'b1; exp_o.mem_to_reg = ld; exp_o.pc_write = 1'b1;
        step(); lat++; mcnt++;
    endtask

    int lat;
    logic [4:0] ops [8] = '{NOP, ADD, SUB, ANDO, ORR, LD, ST, BR};
    logic [3:0] conds [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, AL};

    initial begin
        rst_n = 1'b0; instruction = '0; instr_valid = 1'b0; flags = '0; mem_ready = 1'b0;
        exp_o = '0; check_en = 1'b1;
        step(); step();
        rst_n = 1'b1;
        exp_o = base(); exp_o.instr_req = 1'b1;
        step();

        // Directed scenarios with hand-computed latencies and counts (CW=2 wraps at 4)
        run_instr(mk(ADD, AL, 0, 1, 0), 0, 4'b0000, 0, lat);
        chk("add_latency", lat, 4);      chk("add_count", int'(retired_count), 1);
        run_instr(mk(LD, AL, 0, 0, 0), 0, 4'b0000, 3, lat);
        chk("load_latency", lat, 8);     chk("load_count", int'(retired_count), 2);
        run_instr(mk(ST, AL, 1, 0, 1), 0, 4'b0000, 0, lat);
        chk("store_latency", lat, 4);    chk("store_count", int'(retired_count), 3);
        run_instr(mk(BR, AL, 0, 0, 0), 0, 4'b0000, 0, lat);
        chk("branch_latency", lat, 3);   chk("branch_count_wrap", int'(retired_count), 0);
        run_instr(mk(NOP, AL, 0, 0, 0), 2, 4'b0000, 0, lat);
        chk("nop_latency", lat, 4);      chk("nop_count", int'(retired_count), 1);
        run_instr(mk(ADD, EQ, 1, 0, 1), 0, 4'b0000, 0, lat);
        chk("eq_annul_latency", lat, 2); chk("eq_annul_count", int'(retired_count), 1);
        run_instr(mk(ADD, EQ, 1, 0, 1), 0, 4'b0100, 0, lat);
        chk("eq_exec_latency", lat, 4);  chk("eq_exec_count", int'(retired_count), 2);
        run_instr(mk(5'b11111, AL, 0, 0, 0), 0, 4'b0000, 0, lat);
        chk("illegal_latency", lat, 2);  chk("illegal_count", int'(retired_count), 2);

        // Reset in the middle of an ADD's EXECUTE cycle
        instr_valid = 1'b1; instruction = mk(ADD, AL, 0, 1, 0);
        exp_o = base(); exp_o.instr_req = 1'b1; exp_o.ir_write = 1'b1;
        step();
        instr_valid = 1'b0; flags = 4'b0000;
        exp_o = base();
        step();
        rst_n = 1'b0; mcnt = 0; exp_o = '0;
        #1 chk("rst_async_alu_ctrl", int'(alu_ctrl), 0);
        step();
        rst_n = 1'b1;
        exp_o = base(); exp_o.instr_req = 1'b1;
        #1 chk("post_rst_instr_req", int'(instr_req), 1);
        step();
        chk("post_rst_count", int'(retired_count), 0);

        for (int k = 0; k < 5; k++) run_instr(mk(NOP, AL, 0, 0, 0), 0, 4'b0000, 0, lat);
        chk("nop5_wrap_count", int'(retired_count), 1);

        // Randomized instruction stream
        for (int n = 0; n < 400; n++) begin
            logic [4:0] op;
            logic [3:0] c;
            op = ($urandom_range(0, 9) == 0) ? 5'($urandom) : ops[$urandom_range(0, 7)];
            c  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : conds[$urandom_range(0, 8)];
            run_instr(mk(op, c, 1'($urandom), 1'($urandom), 1'($urandom)),
                      $urandom_range(0, 2), 4'($urandom), $urandom_range(0, 3), lat);
        end
        chk("random_final_count", int'(retired_count), mcnt % (1 << CW));

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Next-generation control unit: multi-cycle FSM replacing the single-cycle combinational decoder. Latches the fetched instruction into an internal IR and sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK. Applies ARM-style conditional execution against NZCV flags and stalls on instruction and data memory handshakes. Sits between instruction/data memory and datapath (register file, ALU, PC); also keeps a retired-instruction counter.

Parameters:
word_size, 32, instruction width
opcode_size, 5, opcode field width; opcode = instruction[word_size-1 -: opcode_size]
cnt_width, 16, retired-instruction counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
instruction  in  word_size  instruction from instruction memory
instr_valid  in  1  instruction is valid this cycle
flags  in  4  {N,Z,C,V} = flags[3:0]
mem_ready  in  1  data memory has completed the access
instr_req  out  1  fetch request
ir_write  out  1  IR load strobe (datapath copy)
pc_write  out  1  PC update strobe
pc_src  out  1  0 = PC+4, 1 = branch target
mem_read  out  1  data memory read
mem_write  out  1  data memory write
mem_to_reg  out  1  writeback selects memory data
reg_write  out  1  register file write enable
flag_write  out  1  latch ALU flags
alu_ctrl  out  opcode_size  ALU operation
alu_src  out  1  0 = register, 1 = immediate operand
imm_src  out  1  immediate extension: 0 = zero-extend, 1 = sign-extend
illegal  out  1  one-cycle pulse on an undefined opcode
retired_count  out  cnt_width  count of executed instructions

Behaviour:
- IR fields: opcode [W-1 -: O]; cond [W-O-1 -: 4]; I bit [W-O-5]; S bit [W-O-6]; X bit [W-O-7] (imm sign-extend).
- Opcodes: NOP 00000, ADD 00110, SUB 00111, AND 01000, ORR 01001, LOAD 10011, STORE 10100, B 11000. Every other opcode is illegal.
- Cond: 0000 EQ Z, 0001 NE !Z, 0010 CS C, 0011 CC !C, 0100 MI N, 0101 PL !N, 0110 VS V, 0111 VC !V, 1110 AL, any other value never executes.
- Outputs are Moore: decoded from state and IR, with no combinational path from instruction.
- Reset (async, rst=0): state=FETCH, IR=0, retired_count=0, all outputs 0. Reset mid-instruction abandons the instruction; no strobes are issued.
- FETCH: instr_req=1. If instr_valid, IR<=instruction, ir_write=1, next state DECODE. Otherwise hold.
- DECODE: cond evaluated against the flags sampled this cycle.
  - Cond fails: pc_write=1, pc_src=0, next FETCH; not retired.
  - Illegal opcode: illegal=1, pc_write=1, next FETCH; not retired.
  - NOP: pc_write=1, next FETCH; retired.
  - Otherwise: next EXECUTE.
- EXECUTE:
  - ALU ops: alu_ctrl=opcode, alu_src=I, imm_src=X, flag_write=S; next WRITEBACK.
  - LOAD/STORE: alu_ctrl=ADD, alu_src=1, imm_src=1; next MEM.
  - B: pc_src=1, pc_write=1, retire; next FETCH.
- MEM: mem_read (LOAD) or mem_write (STORE) held high until mem_ready. A STORE completing with mem_ready: pc_write=1, retire, next FETCH. A LOAD completing with mem_ready: next WRITEBACK.
- WRITEBACK: reg_write=1, mem_to_reg=(opcode==LOAD), pc_write=1, retire; next FETCH.
- Latencies (ready/valid asserted immediately):
  - ALU: 4 cycles
  - LOAD: 5 cycles
  - STORE: 4 cycles
  - B: 3 cycles
  - NOP or annulled: 2 cycles
- retired_count increments by 1 per retire and wraps modulo 2^cnt_width.
- mem_ready outside MEM and instr_valid outside FETCH are ignored.
- alu_ctrl=0 in every state except EXECUTE.

Decomposition:
- Package mcu_pkg: opcode constants, cond constants, state enum (FETCH, DECODE, EXECUTE, MEM, WRITEBACK), flag bit indices.
- One sub-module, cond_check: combinational cond + flags -> pass.
- The FSM, IR and counter stay in multicycle_control_unit.

Test Plan:
- Reset: rst=0 mid-EXECUTE of ADD -> next edge-independent: all outputs 0, retired_count=0; after release, instr_req=1 in FETCH.
- ADD AL (opcode 00110, cond 1110, I=0, S=1), instr_valid=1 -> ir_write cycle 1, EXECUTE alu_ctrl=00110 with flag_write=1, WRITEBACK reg_write=1 and mem_to_reg=0, retired_count=1.
- LOAD with mem_ready low 3 cycles -> mem_read high 4 cycles, then WRITEBACK with reg_write=1 and mem_to_reg=1; total latency 8 cycles.
- EQ-conditional ADD with flags=0000 -> annulled in DECODE: pc_write=1, no reg_write, count unchanged; with flags=0100 -> executes.
- Opcode 11111 -> illegal pulse 1 cycle, pc_write=1, no other strobes; B AL -> pc_src=1, pc_write=1 in EXECUTE.
- cnt_width=2: 5 retired NOPs -> retired_count=1 (wrap).
